// File: rtl/quadra_eval.sv
// Four-stage stall-all evaluator of y = a + b*x2 + c*x2^2 around a combinational coefficient LUT.
// R0 drives the LUT index; R3 rounds half-up and clamps into an unsigned Y_W-bit result.
module quadra_eval #(
  parameter int X_W   = 24,
  parameter int X1_W  = 7,
  parameter int X2_W  = 17,
  parameter int A_W   = 30,
  parameter int B_W   = 22,
  parameter int C_W   = 14,
  parameter int Y_W   = 24,
  parameter int SHIFT = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [X_W-1:0]  x,
  output logic [X1_W-1:0] x1_o,
  input  logic [A_W-1:0]  a_i,
  input  logic [B_W-1:0]  b_i,
  input  logic [C_W-1:0]  c_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Y_W-1:0]  y,
  output logic            sat
);

  localparam int P1_W = B_W + X2_W + 1;
  localparam int P2_W = C_W + X2_W + 1;
  localparam int AA_W = A_W + X2_W;
  localparam int S_W  = A_W + X2_W + 2;
  localparam logic [S_W-1:0] RND  = {{(S_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [S_W-1:0] YMAX = {{(S_W-Y_W){1'b0}}, {Y_W{1'b1}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // R0
  logic            v0;
  logic [X2_W-1:0] r0_x2;

  // R1
  logic            v1;
  logic [A_W-1:0]  r1_a;
  logic [B_W-1:0]  r1_b;
  logic [C_W-1:0]  r1_c;
  logic [X2_W-1:0] r1_x2;
  logic [X2_W-1:0] r1_x2sq;

  // R2
  logic                   v2;
  logic [AA_W-1:0]        r2_aa;
  logic signed [P1_W-1:0] r2_p1;
  logic signed [P2_W-1:0] r2_p2;

  // Combinational stage results
  logic [2*X2_W-1:0]      sq_full;
  logic [X2_W-1:0]        x2sq_n;
  logic signed [P1_W-1:0] p1_n;
  logic signed [P2_W-1:0] p2_n;
  logic signed [S_W-1:0]  s_n;
  logic signed [S_W-1:0]  rnd_n;
  logic signed [S_W-1:0]  r_n;
  logic [Y_W-1:0]         y_n;
  logic                   sat_n;

  always_comb begin
    sq_full = {{X2_W{1'b0}}, r0_x2} * {{X2_W{1'b0}}, r0_x2};
    x2sq_n  = X2_W'(sq_full >> X2_W);
  end

  always_comb begin
    p1_n = $signed({{(X2_W+1){r1_b[B_W-1]}}, r1_b}) * $signed({{(B_W+1){1'b0}}, r1_x2});
    p2_n = $signed({{(X2_W+1){r1_c[C_W-1]}}, r1_c}) * $signed({{(C_W+1){1'b0}}, r1_x2sq});
  end

  // Arithmetic shift floors, so adding half an LSB first gives round-half-up.
  always_comb begin
    s_n   = $signed({2'b00, r2_aa})
          + $signed({{(S_W-P1_W){r2_p1[P1_W-1]}}, r2_p1})
          + $signed({{(S_W-P2_W){r2_p2[P2_W-1]}}, r2_p2});
    rnd_n = s_n + $signed(RND);
    r_n   = rnd_n >>> SHIFT;
    y_n   = r_n[Y_W-1:0];
    sat_n = 1'b0;
    if (r_n < 0) begin
      y_n   = '0;
      sat_n = 1'b1;
    end else if (r_n > $signed(YMAX)) begin
      y_n   = '1;
      sat_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0    <= 1'b0;
      x1_o  <= '0;
      r0_x2 <= '0;
    end else if (advance) begin
      v0    <= in_valid;
      x1_o  <= x[X_W-1:X2_W];
      r0_x2 <= x[X2_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      r1_a    <= '0;
      r1_b    <= '0;
      r1_c    <= '0;
      r1_x2   <= '0;
      r1_x2sq <= '0;
    end else if (advance) begin
      v1      <= v0;
      r1_a    <= a_i;
      r1_b    <= b_i;
      r1_c    <= c_i;
      r1_x2   <= r0_x2;
      r1_x2sq <= x2sq_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      r2_aa <= '0;
      r2_p1 <= '0;
      r2_p2 <= '0;
    end else if (advance) begin
      v2    <= v1;
      r2_aa <= {r1_a, {X2_W{1'b0}}};
      r2_p1 <= p1_n;
      r2_p2 <= p2_n;
    end
  end

  // y/sat only move on valid entries so bubbles leave the last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        y   <= y_n;
        sat <= sat_n;
      end
    end
  end

endmodule
